// File: rtl/text_pixel_gen_if.sv
// Memory-side bus of the text pixel generator: text RAM read port and font ROM read port.
// Both memories are registered, so read data follows the address by one clock.
interface text_pixel_gen_if;
    logic [11:0] tram_addr;
    logic [15:0] tram_data;
    logic [11:0] crom_addr;
    logic [7:0]  crom_data;

    modport master (
        output tram_addr,
        output crom_addr,
        input  tram_data,
        input  crom_data
    );

    modport slave (
        input  tram_addr,
        input  crom_addr,
        output tram_data,
        output crom_data
    );
endinterface

// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: raster coordinates -> text RAM read -> font ROM lookup -> RGB,
// with four register stages so pixels and timing leave exactly four clocks after entry.
module text_pixel_gen #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_de,
    input  logic              in_hsync,
    input  logic              in_vsync,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              cursor_en,
    input  logic [6:0]        cursor_col,
    input  logic [4:0]        cursor_row,
    text_pixel_gen_if.master  mem,
    output logic              out_de,
    output logic              out_hsync,
    output logic              out_vsync,
    output logic [23:0]       out_rgb
);

    localparam logic [11:0] COLS_V = 12'(COLS);
    localparam logic [10:0] X_LIM  = 11'(COLS * 8);
    localparam logic [10:0] Y_LIM  = 11'(ROWS * 16);
    localparam int          FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(BLINK_FRAMES - 1);

    // Per-pixel flags carried down the pipeline; tim = {de, hsync, vsync}.
    typedef struct packed {
        logic [2:0] xfine;
        logic       area;
        logic       cur;
        logic       blink;
        logic [2:0] tim;
    } stage_t;

    function automatic logic [23:0] cga_color(input logic [3:0] idx);
        case (idx)
            4'd0:    return 24'h000000;
            4'd1:    return 24'h0000AA;
            4'd2:    return 24'h00AA00;
            4'd3:    return 24'h00AAAA;
            4'd4:    return 24'hAA0000;
            4'd5:    return 24'hAA00AA;
            4'd6:    return 24'hAA5500;
            4'd7:    return 24'hAAAAAA;
            4'd8:    return 24'h555555;
            4'd9:    return 24'h5555FF;
            4'd10:   return 24'h55FF55;
            4'd11:   return 24'h55FFFF;
            4'd12:   return 24'hFF5555;
            4'd13:   return 24'hFF55FF;
            4'd14:   return 24'hFFFF55;
            4'd15:   return 24'hFFFFFF;
            default: return 24'h000000;
        endcase
    endfunction

    // Constant multiply by COLS as a sum of shifted copies of the row number.
    function automatic logic [11:0] row_times_cols(input logic [5:0] row);
        logic [11:0] acc;
        acc = 12'd0;
        for (int i = 0; i < 12; i++) begin
            if (COLS_V[i]) begin
                acc = acc + (12'(row) << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    logic [11:0]     tram_addr_d, tram_addr_q;
    logic [3:0]      yfine1_d, yfine1_q, yfine2_d, yfine2_q;
    stage_t          s1_d, s1_q, s2_d, s2_q, s3_d, s3_q;
    logic [7:0]      attr3_d, attr3_q;
    logic [23:0]     rgb_d, rgb_q;
    logic [2:0]      tim4_d, tim4_q;
    logic            vsync_prev_d, vsync_prev_q;
    logic [FC_W-1:0] frame_cnt_d, frame_cnt_q;
    logic            blink_phase_d, blink_phase_q;

    logic [6:0]      col_s;
    logic [5:0]      row_s;
    logic            area_s;
    logic            hit_s;
    logic            vsync_rise_s;
    logic            pix_bit_s;
    logic [23:0]     fg_s;
    logic [23:0]     bg_s;

    // Front end: cell decode, text RAM address, stage advance and blink counter.
    always_comb begin
        col_s        = x[9:3];
        row_s        = y[9:4];
        area_s       = in_de && ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
        hit_s        = cursor_en && (col_s == cursor_col) && (row_s == {1'b0, cursor_row})
                       && (y[3:0] >= 4'd14);
        vsync_rise_s = in_vsync && !vsync_prev_q;

        if (area_s) begin
            tram_addr_d = row_times_cols(row_s) + {5'd0, col_s};
        end else begin
            tram_addr_d = 12'd0;
        end

        yfine1_d   = y[3:0];
        s1_d.xfine = x[2:0];
        s1_d.area  = area_s;
        s1_d.cur   = hit_s;
        s1_d.blink = blink_phase_q;
        s1_d.tim   = {in_de, in_hsync, in_vsync};

        yfine2_d   = yfine1_q;
        s2_d       = s1_q;
        s3_d       = s2_q;
        attr3_d    = mem.tram_data[15:8];

        vsync_prev_d  = in_vsync;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (vsync_rise_s) begin
            if (frame_cnt_q == FC_MAX) begin
                frame_cnt_d   = {FC_W{1'b0}};
                blink_phase_d = !blink_phase_q;
            end else begin
                frame_cnt_d   = frame_cnt_q + FC_W'(1);
                blink_phase_d = blink_phase_q;
            end
        end else begin
            frame_cnt_d   = frame_cnt_q;
            blink_phase_d = blink_phase_q;
        end
    end

    // Back end: glyph bit select and colour choice; the cursor only shows in the non-blink phase.
    always_comb begin
        fg_s      = cga_color(attr3_q[3:0]);
        bg_s      = cga_color({1'b0, attr3_q[6:4]});
        pix_bit_s = mem.crom_data[3'd7 - s3_q.xfine];
        tim4_d    = s3_q.tim;
        rgb_d     = 24'h000000;
        if (!s3_q.area) begin
            rgb_d = 24'h000000;
        end else if (s3_q.cur && !s3_q.blink) begin
            rgb_d = fg_s;
        end else if (pix_bit_s && !(attr3_q[7] && s3_q.blink)) begin
            rgb_d = fg_s;
        end else begin
            rgb_d = bg_s;
        end
    end

    // Pipeline and blink state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tram_addr_q   <= 12'd0;
            yfine1_q      <= 4'd0;
            yfine2_q      <= 4'd0;
            s1_q          <= '0;
            s2_q          <= '0;
            s3_q          <= '0;
            attr3_q       <= 8'd0;
            rgb_q         <= 24'h000000;
            tim4_q        <= 3'd0;
            vsync_prev_q  <= 1'b0;
            frame_cnt_q   <= {FC_W{1'b0}};
            blink_phase_q <= 1'b0;
        end else begin
            tram_addr_q   <= tram_addr_d;
            yfine1_q      <= yfine1_d;
            yfine2_q      <= yfine2_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            s3_q          <= s3_d;
            attr3_q       <= attr3_d;
            rgb_q         <= rgb_d;
            tim4_q        <= tim4_d;
            vsync_prev_q  <= vsync_prev_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // The font ROM sees the character from the RAM and the glyph row of the same pixel.
    assign mem.tram_addr = tram_addr_q;
    assign mem.crom_addr = {mem.tram_data[7:0], yfine2_q};

    assign out_rgb                         = rgb_q;
    assign {out_de, out_hsync, out_vsync}  = tim4_q;

endmodule

// File: tb/tb_text_pixel_gen.sv
// Directed bench for text_pixel_gen with registered text RAM / font ROM models.
module tb_text_pixel_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_de, in_hsync, in_vsync;
    logic [9:0]  x, y;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        out_de, out_hsync, out_vsync;
    logic [23:0] out_rgb;

    logic [11:0] ram_addr_sel;
    logic [15:0] ram_word;
    logic [7:0]  rom_byte;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    text_pixel_gen_if mem_if ();

    text_pixel_gen #(.COLS(80), .ROWS(30), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_de      (in_de),
        .in_hsync   (in_hsync),
        .in_vsync   (in_vsync),
        .x          (x),
        .y          (y),
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .mem        (mem_if),
        .out_de     (out_de),
        .out_hsync  (out_hsync),
        .out_vsync  (out_vsync),
        .out_rgb    (out_rgb)
    );

    // One populated text cell; every other cell reads 0. The glyph exists only for that cell's char.
    always @(posedge clk) begin
        mem_if.tram_data <= (mem_if.tram_addr == ram_addr_sel) ? ram_word : 16'h0000;
        mem_if.crom_data <= (mem_if.crom_addr[11:4] == ram_word[7:0]) ? rom_byte : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic de, input logic hs, input logic vs,
                         input logic [9:0] xx, input logic [9:0] yy);
        in_de    = de;
        in_hsync = hs;
        in_vsync = vs;
        x        = xx;
        y        = yy;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    endtask

    task automatic pix_check(input string tag, input logic [9:0] xx, input logic [9:0] yy,
                             input logic vs, input logic [23:0] exp);
        drive(1'b1, 1'b0, vs, xx, yy);
        idle(3);
        chk(tag, 32'(out_rgb), 32'(exp));
    endtask

    task automatic vs_pulse();
        drive(1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
        drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        in_de        = 1'b1;
        in_hsync     = 1'b1;
        in_vsync     = 1'b1;
        x            = 10'd17;
        y            = 10'd35;
        cursor_en    = 1'b0;
        cursor_col   = 7'd0;
        cursor_row   = 5'd0;
        ram_addr_sel = 12'd162;
        ram_word     = 16'h1E41;
        rom_byte     = 8'hFF;

        // reset held with active inputs
        repeat (3) step();
        chk("rst_rgb",   32'(out_rgb),          32'h0);
        chk("rst_de",    32'(out_de),           32'h0);
        chk("rst_hs",    32'(out_hsync),        32'h0);
        chk("rst_vs",    32'(out_vsync),        32'h0);
        chk("rst_taddr", 32'(mem_if.tram_addr), 32'h0);

        // release: first out_de on the 4th edge after the first sample
        in_hsync = 1'b0;
        in_vsync = 1'b0;
        rst_n    = 1'b1;
        step(); step(); step();
        chk("rst_lat3", 32'(out_de), 32'h0);
        step();
        chk("rst_lat4",     32'(out_de),  32'h1);
        chk("rst_lat4_rgb", 32'(out_rgb), 32'hFFFF55);
        idle(4);

        // addressing
        drive(1'b1, 1'b0, 1'b0, 10'd17, 10'd35);
        chk("taddr_162", 32'(mem_if.tram_addr), 32'd162);
        idle(1);
        chk("caddr_413", 32'(mem_if.crom_addr), 32'h413);
        idle(3);

        // pixel row x=16..23, attr 1E, glyph 81
        ram_addr_sel = 12'd2;
        ram_word     = 16'h1E41;
        rom_byte     = 8'h81;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) drive(1'b1, 1'b0, 1'b0, 10'(16 + i), 10'd0);
            else       drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
            if (i >= 3) begin
                chk($sformatf("pix%0d", i - 3), 32'(out_rgb),
                    ((i - 3) == 0 || (i - 3) == 7) ? 32'hFFFF55 : 32'h0000AA);
            end
        end
        idle(2);

        // blanking
        drive(1'b0, 1'b0, 1'b0, 10'd16, 10'd0);
        chk("blank_de_addr", 32'(mem_if.tram_addr), 32'h0);
        idle(3);
        chk("blank_de_rgb", 32'(out_rgb), 32'h0);
        ram_addr_sel = 12'd80;
        drive(1'b1, 1'b0, 1'b0, 10'd640, 10'd0);
        chk("blank_x640_addr", 32'(mem_if.tram_addr), 32'h0);
        idle(3);
        chk("blank_x640_rgb", 32'(out_rgb), 32'h0);
        idle(2);

        // one-cycle hsync pulse
        drive(1'b0, 1'b1, 1'b0, 10'd0, 10'd0);
        idle(2);
        chk("hs_early", 32'(out_hsync), 32'h0);
        idle(1);
        chk("hs_on",    32'(out_hsync), 32'h1);
        idle(1);
        chk("hs_off",   32'(out_hsync), 32'h0);

        // asynchronous reset mid-stream
        ram_addr_sel = 12'd0;
        ram_word     = 16'h8F41;
        rom_byte     = 8'hFF;
        repeat (4) drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
        chk("pre_rst_rgb", 32'(out_rgb), 32'hFFFFFF);
        rst_n = 1'b0;
        #1;
        chk("async_rgb", 32'(out_rgb), 32'h0);
        chk("async_de",  32'(out_de),  32'h0);
        #1;
        rst_n = 1'b1;
        idle(2);

        // blink with BLINK_FRAMES=2
        pix_check("blink_f0", 10'd0, 10'd0, 1'b0, 24'hFFFFFF);
        vs_pulse();
        pix_check("blink_f1", 10'd0, 10'd0, 1'b0, 24'hFFFFFF);
        pix_check("blink_same_cycle", 10'd0, 10'd0, 1'b1, 24'hFFFFFF);
        pix_check("blink_f2", 10'd0, 10'd0, 1'b0, 24'h000000);
        vs_pulse();
        pix_check("blink_f3", 10'd0, 10'd0, 1'b0, 24'h000000);
        vs_pulse();
        pix_check("blink_f4", 10'd0, 10'd0, 1'b0, 24'hFFFFFF);

        // cursor at (5,0), attr 07, blank glyph
        cursor_en    = 1'b1;
        cursor_col   = 7'd5;
        cursor_row   = 5'd0;
        ram_addr_sel = 12'd5;
        ram_word     = 16'h0741;
        rom_byte     = 8'h00;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) drive(1'b1, 1'b0, 1'b0, 10'(40 + i), 10'd14);
            else       drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
            if (i >= 3) chk($sformatf("cur14_%0d", i - 3), 32'(out_rgb), 32'hAAAAAA);
        end
        pix_check("cur15",   10'd47, 10'd15, 1'b0, 24'hAAAAAA);
        pix_check("cur13",   10'd40, 10'd13, 1'b0, 24'h000000);
        cursor_en = 1'b0;
        pix_check("cur_off", 10'd40, 10'd14, 1'b0, 24'h000000);
        cursor_en = 1'b1;
        vs_pulse();
        vs_pulse();
        pix_check("cur_blink", 10'd40, 10'd14, 1'b0, 24'h000000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/text_pixel_gen.md
# text_pixel_gen

Text-mode pixel generator for the HDMI video path. It converts raster pixel coordinates into text-buffer reads and character-font ROM lookups, then produces one 24-bit RGB pixel per clock. Timing signals are delayed to stay aligned with the pixels. It sits between the video timing generator (upstream) and the HDMI encoder (downstream), and drives the address of the 4Kx8 registered character font ROM.

## Interface
- COLS, 80: text columns; glyphs are 8 pixels wide.
- ROWS, 30: text rows; glyphs are 16 pixels tall.
- BLINK_FRAMES, 32: number of frames per blink half-period.
- clk  in  1  pixel clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_de, in_hsync, in_vsync  in  1 each  timing from the timing generator; all active-high.
- x, y  in  10 each  current pixel coordinates; valid when in_de=1.
- tram_addr  out  12  text RAM address, registered; equals row*COLS+col.
- tram_data  in  16  text RAM read data {attr[7:0], char[7:0]}; valid 1 cycle after tram_addr.
- crom_addr  out  12  font ROM address {char[7:0], glyph_row[3:0]}; combinational from tram_data and the delayed glyph row.
- crom_data  in  8  font ROM row bits, MSB = leftmost pixel; valid 1 cycle after crom_addr.
- cursor_en  in  1  cursor enable.
- cursor_col  in  7  cursor column.
- cursor_row  in  5  cursor row.
- out_de, out_hsync, out_vsync  out  1 each  delayed timing signals.
- out_rgb  out  24  {R,G,B} pixel.

## Operation
- Cell decode:
  - col = x[9:3], row = y[9:4], xfine = x[2:0], yfine = y[3:0].
  - Compute row*COLS with shifts and adds (row*80 = (row<<6)+(row<<4)). Use a 12-bit result; truncation never occurs for default parameters.
- In-area: in_de=1 AND x < COLS*8 AND y < ROWS*16.
  - Outside the area, tram_addr is 0 and out_rgb is 0.
- Attribute byte:
  - attr[3:0] = foreground index (0–15).
  - attr[6:4] = background index (0–7).
  - attr[7] = blink.
- Palette: fixed 16-entry CGA table.
  - 0=000000, 1=0000AA, 2=00AA00, 3=00AAAA, 4=AA0000, 5=AA00AA, 6=AA5500, 7=AAAAAA
  - 8=555555, 9=5555FF, 10=55FF55, 11=55FFFF, 12=FF5555, 13=FF55FF, 14=FFFF55, 15=FFFFFF
- Pixel bit = crom_data[7 - xfine_d].
  - Bit 1: pixel uses the foreground colour. Exception: attr[7]=1 and blink_phase=1, then the background colour is used.
  - Bit 0: pixel uses the background colour.
- Cursor overrides the pixel with the foreground colour when all of the following hold:
  - cursor_en=1 and blink_phase=0;
  - the cell equals (cursor_col, cursor_row);
  - yfine is 14 or 15.
  - The result is a solid underline.
  - Cursor inputs are sampled at stage S1 together with x/y.
- Blink counter:
  - A frame counter increments on each rising edge of in_vsync, detected with a registered previous value.
  - When the counter reaches BLINK_FRAMES-1 and another rising edge occurs, the counter wraps to 0 and blink_phase toggles.
  - A new frame never changes blink_phase mid-pixel-pipeline; blink_phase is sampled at S1.
- Pipeline, with k = the edge that samples the inputs:
  - S1 (edge k+1): register tram_addr, xfine, yfine, in-area flag, cursor-hit flag, blink_phase and timing signals.
  - S2 (edge k+2): text RAM data is valid. Register attr, xfine, in-area, cursor and timing. crom_addr is driven combinationally as {tram_data[7:0], yfine_S1}.
  - S3 (edge k+3): the font ROM registers its data. This stage delays attr and flags by one more register stage.
  - S4 (edge k+4): register out_rgb, out_de, out_hsync and out_vsync.

## Timing
- Latency: inputs sampled at edge k appear on out_* after edge k+4, for every signal. Throughput is 1 pixel per clock with no stalls.
- Reset values (immediate on rst_n=0) are all 0: out_rgb, out_de, out_hsync, out_vsync, tram_addr, all pipeline registers, the frame counter and blink_phase.
- Reset mid-frame: outputs drop to 0 asynchronously. The first valid output appears on the 4th edge after the first input sample following release.
- Simultaneous events:
  - A vsync rising edge and a cursor-cell pixel in the same cycle: the pixel uses the old blink_phase.
  - Blink attribute and cursor on the same pixel: the cursor is shown only when blink_phase=0, so the two never conflict.
- Sync pulse widths and polarity pass through unchanged.

## Test plan
- Reset: hold rst_n=0 with in_de=1 and active inputs -> out_rgb=000000, out_de/hsync/vsync=0 and tram_addr=0. After release, the first valid out_de appears 4 edges after the first sampled in_de=1.
- Addressing: x=17, y=35, in_de=1 -> tram_addr=162 after edge k+1. Then tram_data=0x1E41 -> crom_addr=0x413.
- Pixels: attr 0x1E, crom_data=0x81, x=16..23 on one row -> out_rgb sequence FFFF55, then 0000AA ×6, then FFFF55, starting 4 cycles after x=16.
- Blanking: in_de=0, or x=640 -> out_rgb=000000 and tram_addr=0. A 1-cycle in_hsync pulse gives a 1-cycle out_hsync pulse exactly 4 cycles later.
- Blink: BLINK_FRAMES=2, attr 0x8F, glyph bit=1 -> FFFFFF in frames 0–1, 000000 after the 2nd vsync rise, FFFFFF again after the 4th.
- Cursor: cursor_en=1, col 5, row 0, attr 0x07, blank glyph -> x=40..47 at y=14/15 show AAAAAA and at y=13 show 000000. While blink_phase=1, y=14 shows 000000.
